// File: rtl/line_buf_ctrl_pkg.sv
// Shared definitions for the edge-path line buffer controller and read-address generator.
// Holds the FSM state encoding and the default frame geometry.
// No logic; imported by line_buf_ctrl and pix_pos_cnt.
package line_buf_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Default frame geometry, also used by the read-address generator.
    localparam int LB_COLUMN_SIZE = 1280;
    localparam int LB_ROW_SIZE    = 1024;

endpackage

// File: rtl/pix_pos_cnt.sv
// Column/row position counter: holds the position of the next pixel to be accepted.
// Latency: counter advances on the clock after an en beat; eol/eof are combinational on the held position.
// Backpressure: none; en gaps simply hold the position, clr has priority over en.
// Ports: clk, aclr (async, active-high), clr, en -> col, row, eol (last column), eof (last pixel of frame).
module pix_pos_cnt
    import line_buf_ctrl_pkg::*;
#(
    parameter int COLUMN_SIZE = LB_COLUMN_SIZE,
    parameter int ROW_SIZE    = LB_ROW_SIZE,
    parameter int ADDR_W      = 11,
    parameter int ROW_W       = 11
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] col,
    output logic [ROW_W-1:0]  row,
    output logic              eol,
    output logic              eof
);

    logic [ADDR_W-1:0] col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;

    assign eol = (col_q == ADDR_W'(COLUMN_SIZE - 1));
    assign eof = eol && (row_q == ROW_W'(ROW_SIZE - 1));
    assign col = col_q;
    assign row = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (en) begin
            if (eol) begin
                col_d = '0;
                // Wrapping the row at frame end leaves the counter at (0,0) for the next frame.
                row_d = eof ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// Sequences the two line RAMs feeding the 3x3 edge window: write/read enables, position, window/frame flags.
// Latency: every output is registered, valid 1 cycle after the iDVAL beat it describes.
// Backpressure: none; iDVAL gaps hold counters and zero the enables, iFVAL drop aborts the frame.
// Ports: clk, aclr, iFVAL, iDVAL -> rama/ramb_wren, wr_add, rama/ramb_rden, rdadd_clr, col_cnt, row_cnt,
//        oWIN_VAL, oFRAME_DONE.
module line_buf_ctrl
    import line_buf_ctrl_pkg::*;
#(
    parameter int COLUMN_SIZE = LB_COLUMN_SIZE,
    parameter int ROW_SIZE    = LB_ROW_SIZE,
    parameter int ADDR_W      = 11,
    parameter int ROW_W       = 11
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              iFVAL,
    input  logic              iDVAL,
    output logic              rama_wren,
    output logic              ramb_wren,
    output logic [ADDR_W-1:0] wr_add,
    output logic              rama_rden,
    output logic              ramb_rden,
    output logic              rdadd_clr,
    output logic [ADDR_W-1:0] col_cnt,
    output logic [ROW_W-1:0]  row_cnt,
    output logic              oWIN_VAL,
    output logic              oFRAME_DONE
);

    state_t            state_q, state_d;
    logic              fval_q;
    logic              rama_wren_q, rama_wren_d;
    logic              ramb_wren_q, ramb_wren_d;
    logic              rama_rden_q, rama_rden_d;
    logic              ramb_rden_q, ramb_rden_d;
    logic              rdadd_clr_q, rdadd_clr_d;
    logic              win_val_q, win_val_d;
    logic              frame_done_q, frame_done_d;
    logic [ADDR_W-1:0] col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;

    logic              start, live, abort, beat, cnt_clr;
    logic [ADDR_W-1:0] pos_col;
    logic [ROW_W-1:0]  pos_row;
    logic              pos_eol, pos_eof;

    // A frame starts on the iFVAL edge; a beat on that same cycle is pixel (0,0).
    assign start   = (state_q == ST_IDLE) && iFVAL && !fval_q;
    assign live    = (state_q == ST_FILL) || (state_q == ST_RUN);
    assign abort   = live && !iFVAL;
    assign beat    = iFVAL && iDVAL && (start || live);
    // Position is pinned at (0,0) while idle so a coincident start beat lands on column 0.
    assign cnt_clr = abort || ((state_q == ST_IDLE) && !beat);

    pix_pos_cnt #(
        .COLUMN_SIZE(COLUMN_SIZE),
        .ROW_SIZE   (ROW_SIZE),
        .ADDR_W     (ADDR_W),
        .ROW_W      (ROW_W)
    ) u_pos (
        .clk (clk),
        .aclr(aclr),
        .clr (cnt_clr),
        .en  (beat),
        .col (pos_col),
        .row (pos_row),
        .eol (pos_eol),
        .eof (pos_eof)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)  state_d = ST_FILL;
            ST_FILL: if (abort)  state_d = ST_IDLE;
            ST_RUN:  if (abort)  state_d = ST_IDLE;
            ST_DONE: if (!iFVAL) state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
        if (beat) begin
            if (pos_eof)      state_d = ST_DONE;
            else if (pos_eol) state_d = ST_RUN;
        end

        // Even rows go to RAM A, odd rows to RAM B; the RAM being written is read
        // at the same address and returns the row two above (read-old-data).
        rama_wren_d  = beat && !pos_row[0];
        ramb_wren_d  = beat &&  pos_row[0];
        rama_rden_d  = beat && (pos_row != '0);
        ramb_rden_d  = beat && (pos_row > ROW_W'(1));
        win_val_d    = beat && (pos_row > ROW_W'(1)) && (pos_col > ADDR_W'(1));
        frame_done_d = beat && pos_eof;
        rdadd_clr_d  = start;

        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        if (beat) begin
            col_cnt_d = pos_col;
            row_cnt_d = pos_row;
        end else if (abort || start) begin
            col_cnt_d = '0;
            row_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q      <= ST_IDLE;
            // Treated as already high so a reset inside a frame waits for a fresh iFVAL edge.
            fval_q       <= 1'b1;
            rama_wren_q  <= 1'b0;
            ramb_wren_q  <= 1'b0;
            rama_rden_q  <= 1'b0;
            ramb_rden_q  <= 1'b0;
            rdadd_clr_q  <= 1'b0;
            win_val_q    <= 1'b0;
            frame_done_q <= 1'b0;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            fval_q       <= iFVAL;
            rama_wren_q  <= rama_wren_d;
            ramb_wren_q  <= ramb_wren_d;
            rama_rden_q  <= rama_rden_d;
            ramb_rden_q  <= ramb_rden_d;
            rdadd_clr_q  <= rdadd_clr_d;
            win_val_q    <= win_val_d;
            frame_done_q <= frame_done_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
        end
    end

    assign rama_wren   = rama_wren_q;
    assign ramb_wren   = ramb_wren_q;
    assign rama_rden   = rama_rden_q;
    assign ramb_rden   = ramb_rden_q;
    assign rdadd_clr   = rdadd_clr_q;
    assign oWIN_VAL    = win_val_q;
    assign oFRAME_DONE = frame_done_q;
    assign col_cnt     = col_cnt_q;
    assign row_cnt     = row_cnt_q;
    assign wr_add      = col_cnt_q;

endmodule
